// File: rtl/shifter_seq_pkg.sv
// ============================================================================
// Module      : shifter_seq_pkg
// Description : Shared defaults and FSM state encoding for the sequential
//               shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_seq_pkg;

  localparam int c_width_default = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shifter_seq_step.sv
// ============================================================================
// Module      : shifter_seq_step
// Description : Combinational single-bit shift/rotate step.
//               Rotate input exists only with SHIFTER_SEQ_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_seq_step
  import shifter_seq_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic             dir,
  input  logic             arith,
`ifdef SHIFTER_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] stepped
);

  logic w_fill;

  always_comb begin
    w_fill = arith & data[WIDTH-1];
    if (dir) begin
      stepped = {w_fill, data[WIDTH-1:1]};
    end else begin
      stepped = {data[WIDTH-2:0], 1'b0};
    end
`ifdef SHIFTER_SEQ_ROTATE_EN
    // Rotation overrides the fill choice entirely.
    if (rot) begin
      if (dir) begin
        stepped = {data[0], data[WIDTH-1:1]};
      end else begin
        stepped = {data[WIDTH-2:0], data[WIDTH-1]};
      end
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/shifter_seq.sv
// ============================================================================
// Module      : shifter_seq
// Description : Multi-cycle shifter, one bit per clock; optional rotate mode
//               enabled by macro SHIFTER_SEQ_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_seq
  import shifter_seq_pkg::*;
#(
  parameter int WIDTH   = c_width_default,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sh_dir,
  input  logic               sh_arith,
`ifdef SHIFTER_SEQ_ROTATE_EN
  input  logic               sh_rot,
`endif
  input  logic [SHAMT_W-1:0] sh_amt,
  input  logic [WIDTH-1:0]   d_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   d_out
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   w_work_step;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_dir;
  logic               r_arith;
  logic [WIDTH-1:0]   r_dout;
  logic               r_done;
  logic               w_cnt_zero;
`ifdef SHIFTER_SEQ_ROTATE_EN
  logic               r_rot;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  shifter_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .dir     (r_dir),
    .arith   (r_arith),
`ifdef SHIFTER_SEQ_ROTATE_EN
    .rot     (r_rot),
`endif
    .data    (r_work),
    .stepped (w_work_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)      w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_cnt_zero) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands and mode are captured once at acceptance, so later input
  // changes cannot disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_arith <= 1'b0;
      r_dout  <= '0;
      r_done  <= 1'b0;
`ifdef SHIFTER_SEQ_ROTATE_EN
      r_rot   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work  <= d_in;
            r_cnt   <= sh_amt;
            r_dir   <= sh_dir;
            r_arith <= sh_arith;
`ifdef SHIFTER_SEQ_ROTATE_EN
            r_rot   <= sh_rot;
`endif
          end
        end
        ST_SHIFT: begin
          if (!w_cnt_zero) begin
            r_work <= w_work_step;
            r_cnt  <= r_cnt - 1'b1;
          end else begin
            r_dout <= r_work;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == ST_SHIFT);
  assign done  = r_done;
  assign d_out = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_shifter_seq.sv
// ============================================================================
// Module      : tb_shifter_seq
// Description : Scoreboard bench for shifter_seq (WIDTH=32); rotate cases
//               included when SHIFTER_SEQ_ROTATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shifter_seq;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sh_dir = 1'b0;
  logic          sh_arith = 1'b0;
  logic          sh_rot = 1'b0;
  logic [SW-1:0] sh_amt = '0;
  logic [W-1:0]  d_in = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  d_out;

  shifter_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sh_dir   (sh_dir),
    .sh_arith (sh_arith),
`ifdef SHIFTER_SEQ_ROTATE_EN
    .sh_rot   (sh_rot),
`endif
    .sh_amt   (sh_amt),
    .d_in     (d_in),
    .busy     (busy),
    .done     (done),
    .d_out    (d_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp;
    int           k;
    int           amt;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  bit    stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input bit dir,
                                         input bit arith, input bit rot, input int amt);
    logic [W-1:0] r;
    if (rot) begin
      if (amt == 0) r = d;
      else if (dir) r = (d >> amt) | (d << (W - amt));
      else          r = (d << amt) | (d >> (W - amt));
    end else if (!dir) begin
      r = d << amt;
    end else if (arith) begin
      r = $signed(d) >>> amt;
    end else begin
      r = d >> amt;
    end
    return r;
  endfunction

  // Called at a negedge where busy=0 and start is being driven: the next
  // posedge accepts, and that edge is cycle cyc+1.
  task automatic push(input logic [W-1:0] exp);
    item_t it;
    it.exp = exp;
    it.k   = cyc + 1;
    it.amt = int'(sh_amt);
    q.push_back(it);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL wait_idle timeout at cycle %0d: got busy=1 expected busy=0", cyc);
      errors++;
    end
  endtask

  task automatic issue(input logic [W-1:0] d, input bit dir, input bit arith,
                       input bit rot, input int amt, input logic [W-1:0] exp);
    wait_idle();
    d_in = d; sh_dir = dir; sh_arith = arith; sh_rot = rot; sh_amt = amt[SW-1:0];
    start = 1'b1;
    push(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: expected busy/done follow from the oldest outstanding op.
  always @(negedge clk) begin
    if (!rst) begin
      bit exp_busy;
      bit exp_done;
      exp_busy = (q.size() > 0) && (cyc >= q[0].k) && (cyc <= q[0].k + q[0].amt);
      exp_done = (q.size() > 0) && (cyc == q[0].k + q[0].amt + 1);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        chk("d_out", d_out, q[0].exp);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_dout", d_out, 32'd0);

    issue(32'h8000_0001, 1'b0, 1'b0, 1'b0, 4, 32'h0000_0010);
    issue(32'hF000_0000, 1'b1, 1'b1, 1'b0, 4, 32'hFF00_0000);
    issue(32'hF000_0000, 1'b1, 1'b0, 1'b0, 4, 32'h0F00_0000);
    issue(32'h1234_5678, 1'b1, 1'b1, 1'b0, 0, 32'h1234_5678);
    issue(32'h8000_0000, 1'b1, 1'b1, 1'b0, 31, 32'hFFFF_FFFF);
    issue(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 31, 32'h8000_0000);
`ifdef SHIFTER_SEQ_ROTATE_EN
    issue(32'h8000_0001, 1'b1, 1'b1, 1'b1, 1, 32'hC000_0000);
    issue(32'h8000_0001, 1'b0, 1'b0, 1'b1, 1, 32'h0000_0003);
`endif

    // Back-to-back: new request presented in the DONE cycle.
    issue(32'h0000_00AA, 1'b0, 1'b0, 1'b0, 2, 32'h0000_02A8);
    begin
      int n = 0;
      while (!done && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    d_in = 32'h1; sh_dir = 1'b0; sh_arith = 1'b0; sh_rot = 1'b0; sh_amt = 5'd1;
    start = 1'b1;
    push(32'h0000_0002);
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation, with an ignored second request while busy.
    issue(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 8, 32'h0);
    d_in = 32'h5555_5555; sh_amt = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_dout", d_out, 32'd0);
    q.delete();
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Random traffic; inputs churn every cycle, including while busy.
    for (int i = 0; i < 3000; i++) begin
      d_in     = $urandom;
      sh_dir   = $urandom_range(0, 1);
      sh_arith = $urandom_range(0, 1);
`ifdef SHIFTER_SEQ_ROTATE_EN
      sh_rot   = $urandom_range(0, 1);
`else
      sh_rot   = 1'b0;
`endif
      sh_amt   = SW'($urandom_range(0, W - 1));
      start    = ($urandom_range(0, 2) == 0);
      if (start && !busy) push(model(d_in, sh_dir, sh_arith, sh_rot, int'(sh_amt)));
      @(negedge clk);
    end
    start = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    int n;
    wait (stim_done);
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain timeout: got %0d outstanding expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
